// File: rtl/mp_pkg.sv
// Shared constants and types for the multi-precision arithmetic slice.
package mp_pkg;

    localparam int unsigned WIDTH = 1027;

    // Adder start-to-done latency; only benches depend on it.
    localparam int unsigned L = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mp_final_sub.sv
// Final conditional-subtraction sequencer: drives an external mpadder to
// compute X - M up to MAX_SUB times, stopping early on the first borrow.
module mp_final_sub
    import mp_pkg::*;
#(
    parameter int unsigned WIDTH   = mp_pkg::WIDTH,
    parameter int unsigned MAX_SUB = 2,
    parameter int unsigned CNT_W   = $clog2(MAX_SUB + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] nsub,
    output logic             sat,
    output logic             busy,
    output logic             done,
    output logic             add_start,
    output logic             add_subtract,
    output logic [WIDTH-1:0] add_in_a,
    output logic [WIDTH-1:0] add_in_b,
    input  logic [WIDTH:0]   add_result,
    input  logic             add_done
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SUB);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, m_q;
    logic [CNT_W-1:0] nsub_inc;
    logic             borrow;
    logic             last_pass;

    assign borrow    = add_result[WIDTH];
    assign nsub_inc  = nsub + CNT_W'(1);
    assign last_pass = (nsub_inc == MAX_CNT);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT: begin
                if (add_done) begin
                    state_d = (borrow || last_pass) ? DONE : ISSUE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        add_start    = (state_q == ISSUE);
        busy         = (state_q != IDLE);
        done         = (state_q == DONE);
        add_subtract = (state_q != IDLE);
        add_in_a     = x_q;
        add_in_b     = m_q;
    end

    // result is loaded on the WAIT->DONE transition so it is already valid
    // in the cycle done is asserted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_q    <= '0;
            m_q    <= '0;
            result <= '0;
            nsub   <= '0;
            sat    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q  <= in_x;
                        m_q  <= in_m;
                        nsub <= '0;
                        sat  <= 1'b0;
                    end
                end
                WAIT: begin
                    if (add_done) begin
                        if (borrow) begin
                            result <= x_q;
                        end else begin
                            x_q  <= add_result[WIDTH-1:0];
                            nsub <= nsub_inc;
                            if (last_pass) begin
                                sat    <= 1'b1;
                                result <= add_result[WIDTH-1:0];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_final_sub.sv
// Directed bench for mp_final_sub with a behavioural fixed-latency adder.
module tb_mp_final_sub;
    import mp_pkg::*;

    localparam int unsigned W     = mp_pkg::WIDTH;
    localparam int unsigned CW    = 2;

    logic          clk;
    logic          resetn;
    logic          start;
    logic [W-1:0]  in_x, in_m;
    logic [W-1:0]  result;
    logic [CW-1:0] nsub;
    logic          sat, busy, done;
    logic          add_start, add_subtract;
    logic [W-1:0]  add_in_a, add_in_b;
    logic [W:0]    add_result;
    logic          add_done;

    logic [W:0]    msum;
    logic          mdone;
    logic          spur;
    int unsigned   mcnt;

    int checks;
    int errors;

    mp_final_sub #(.WIDTH(W), .MAX_SUB(2), .CNT_W(CW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .in_x         (in_x),
        .in_m         (in_m),
        .result       (result),
        .nsub         (nsub),
        .sat          (sat),
        .busy         (busy),
        .done         (done),
        .add_start    (add_start),
        .add_subtract (add_subtract),
        .add_in_a     (add_in_a),
        .add_in_b     (add_in_b),
        .add_result   (add_result),
        .add_done     (add_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder model: result and done appear L cycles after add_start.
    always @(posedge clk) begin
        if (!resetn) begin
            mcnt  <= 0;
            mdone <= 1'b0;
            msum  <= '0;
        end else begin
            mdone <= 1'b0;
            if (add_start) begin
                mcnt <= L - 1;
                msum <= {1'b0, add_in_a} + {1'b1, ~add_in_b} + {{W{1'b0}}, 1'b1};
            end else if (mcnt != 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1) mdone <= 1'b1;
            end
        end
    end

    assign add_done   = mdone | spur;
    assign add_result = msum;

    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got ..%h expected ..%h", tag, got[127:0], exp[127:0]);
        end
    endtask

    task automatic run_req(input string tag, input logic [W-1:0] x, input logic [W-1:0] m,
                           input logic [W-1:0] r_exp, input int n_exp, input int s_exp,
                           input int done_exp, input int start2_exp,
                           input int inj_a, input int inj_b);
        int n_starts, c1, c2, n_done, done_at, bad_busy, bad_sub;
        logic [W-1:0] res_at_done;
        n_starts = 0; c1 = 0; c2 = 0; n_done = 0; done_at = 0;
        bad_busy = 0; bad_sub = 0; res_at_done = '0;
        @(negedge clk);
        start = 1'b1;
        in_x  = x;
        in_m  = m;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (add_start) begin
                n_starts++;
                if (n_starts == 1) c1 = c; else c2 = c;
            end
            if (done) begin
                n_done++;
                done_at = c;
                res_at_done = result;
            end
            if (busy !== (c <= done_exp)) bad_busy++;
            if (add_subtract !== busy) bad_sub++;
            start = (c == inj_a) || (c == inj_b);
            in_x  = {W{1'b1}};
            in_m  = '0;
        end
        start = 1'b0;
        check({tag, " done_cycle"}, W'(done_at), W'(done_exp));
        check({tag, " done_count"}, W'(n_done), W'(1));
        check({tag, " first_add_start"}, W'(c1), W'(1));
        check({tag, " second_add_start"}, W'(c2), W'(start2_exp));
        check({tag, " add_start_count"}, W'(n_starts), W'(start2_exp != 0 ? 2 : 1));
        check({tag, " result_at_done"}, {1'b0, res_at_done}, {1'b0, r_exp});
        check({tag, " result_held"}, {1'b0, result}, {1'b0, r_exp});
        check({tag, " nsub"}, W'(nsub), W'(n_exp));
        check({tag, " sat"}, W'(sat), W'(s_exp));
        check({tag, " busy_window"}, W'(bad_busy), W'(0));
        check({tag, " subtract_eq_busy"}, W'(bad_sub), W'(0));
    endtask

    initial begin
        logic [W-1:0] ones, ones_m2;
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        start  = 1'b0;
        spur   = 1'b0;
        in_x   = '0;
        in_m   = '0;
        ones    = {W{1'b1}};
        ones_m2 = ones - W'(2);

        repeat (3) @(negedge clk);
        check("rst result", {1'b0, result}, '0);
        check("rst nsub", W'(nsub), W'(0));
        check("rst sat", W'(sat), W'(0));
        check("rst busy", W'(busy), W'(0));
        check("rst done", W'(done), W'(0));
        check("rst add_start", W'(add_start), W'(0));
        check("rst add_subtract", W'(add_subtract), W'(0));
        check("rst add_in_a", {1'b0, add_in_a}, '0);
        resetn = 1'b1;

        run_req("x10m3", W'(10), W'(3), W'(4), 2, 1, 9, 5, 2, 9);
        run_req("x5m7", W'(5), W'(7), W'(5), 0, 0, 5, 0, 0, 0);
        run_req("x7m7", W'(7), W'(7), W'(0), 1, 0, 9, 5, 0, 0);
        run_req("ones_m1", ones, W'(1), ones_m2, 2, 1, 9, 5, 0, 0);
        run_req("x123m0", W'(123), W'(0), W'(123), 2, 1, 9, 5, 0, 0);

        // Spurious add_done while idle must not move the FSM.
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        check("spur busy", W'(busy), W'(0));
        check("spur done", W'(done), W'(0));
        check("spur nsub", W'(nsub), W'(2));
        check("spur result", {1'b0, result}, {1'b0, W'(123)});
        @(negedge clk);
        check("spur busy_late", W'(busy), W'(0));

        // Reset while waiting on the adder.
        @(negedge clk);
        start = 1'b1;
        in_x  = W'(10);
        in_m  = W'(3);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 3) resetn = 1'b0;
        end
        check("midrst busy", W'(busy), W'(0));
        check("midrst done", W'(done), W'(0));
        check("midrst result", {1'b0, result}, '0);
        check("midrst add_start", W'(add_start), W'(0));
        resetn = 1'b1;

        run_req("after_rst", W'(5), W'(7), W'(5), 0, 0, 5, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
